// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: datapath/VU handshake bundle for the pipeline hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 16
) ();
    logic              d_valid;
    logic [3:0]        d_rs1;
    logic [3:0]        d_rs2;
    logic              d_use_rs1;
    logic              d_use_rs2;
    logic              d_vec;
    logic [3:0]        e_rd;
    logic              e_regWrite;
    logic [1:0]        e_resultSrc;
    logic              e_pcSrc;
    logic [3:0]        e_rs1;
    logic [3:0]        e_rs2;
    logic [3:0]        m_rd;
    logic [3:0]        w_rd;
    logic              m_regWrite;
    logic              w_regWrite;
    logic              vu_done;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              vu_start;
    logic              vu_abort;
    logic              err_timeout;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_vec,
               e_rd, e_regWrite, e_resultSrc, e_pcSrc, e_rs1, e_rs2,
               m_rd, w_rd, m_regWrite, w_regWrite, vu_done,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b,
               vu_start, vu_abort, err_timeout, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_vec,
               e_rd, e_regWrite, e_resultSrc, e_pcSrc, e_rs1, e_rs2,
               m_rd, w_rd, m_regWrite, w_regWrite, vu_done,
        output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b,
               vu_start, vu_abort, err_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding sequencer with VU issue and timeout watchdog
module pipeline_hazard_ctrl #(
    parameter int         VU_TIMEOUT = 64,
    parameter logic [1:0] LOAD_SRC   = 2'b01,
    parameter int         PERF_W     = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int CW = $clog2(VU_TIMEOUT);

    typedef enum logic {RUN, VU_BUSY} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic [PERF_W-1:0] r_stall_cnt;

    logic w_lu, w_br, w_lu_st, w_issue, w_busy, w_to, w_hold, w_stall;
    logic w_ma, w_wa, w_mb, w_wb;

    // Hazard detection and per-state control decode; everything is held low while in reset
    always_comb begin
        w_ma    = bus.m_regWrite && bus.m_rd != 4'd0 && bus.m_rd == bus.e_rs1;
        w_wa    = bus.w_regWrite && bus.w_rd != 4'd0 && bus.w_rd == bus.e_rs1;
        w_mb    = bus.m_regWrite && bus.m_rd != 4'd0 && bus.m_rd == bus.e_rs2;
        w_wb    = bus.w_regWrite && bus.w_rd != 4'd0 && bus.w_rd == bus.e_rs2;
        w_lu    = bus.d_valid && bus.e_regWrite && bus.e_resultSrc == LOAD_SRC && bus.e_rd != 4'd0 &&
                  ((bus.d_use_rs1 && bus.d_rs1 == bus.e_rd) || (bus.d_use_rs2 && bus.d_rs2 == bus.e_rd));
        w_br    = r_state == RUN && bus.e_pcSrc;
        w_lu_st = r_state == RUN && !bus.e_pcSrc && w_lu;
        w_issue = r_state == RUN && !bus.e_pcSrc && !w_lu && bus.d_valid && bus.d_vec;
        w_busy  = r_state == VU_BUSY;
        w_to    = w_busy && !bus.vu_done && r_cnt == CW'(VU_TIMEOUT - 1);
        w_hold  = w_busy && !bus.vu_done && !w_to;
        w_stall = reset_n && (w_lu_st || w_issue || w_hold);
        bus.stall_f     = w_stall;
        bus.stall_d     = w_stall;
        bus.flush_d     = reset_n && w_br;
        bus.flush_e     = reset_n && (w_br || w_lu_st || w_issue || w_hold);
        bus.vu_start    = reset_n && w_issue;
        bus.vu_abort    = reset_n && w_to;
        bus.fwd_a       = !reset_n ? 2'b00 : w_ma ? 2'b10 : w_wa ? 2'b01 : 2'b00;
        bus.fwd_b       = !reset_n ? 2'b00 : w_mb ? 2'b10 : w_wb ? 2'b01 : 2'b00;
        bus.err_timeout = r_err;
        bus.stall_cnt   = r_stall_cnt;
    end

    // FSM, VU busy counter, sticky timeout flag and saturating stall counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_state <= VU_BUSY;
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
                if (bus.vu_done || w_to) r_state <= RUN;
            end
            if (w_to) r_err <= 1'b1;
            if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule
